// File: rtl/scan_ldclr_pipe.sv
// WIDTH x DEPTH scannable register pipeline with shared advance, synchronous clear,
// per-stage valid tracking and a saturating scan-shift counter.
module scan_ldclr_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNTW  = $clog2(WIDTH*DEPTH+1)
) (
  input  logic             CK,
  input  logic             RB,
  input  logic [WIDTH-1:0] D,
  input  logic             VI,
  input  logic             LD,
  input  logic             CLRB,
  input  logic             SEL,
  input  logic             TD,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QB,
  output logic             VO,
  output logic             SO,
  output logic [CNTW-1:0]  SCNT,
  output logic             SDONE
);

  localparam int N = WIDTH * DEPTH;
  localparam logic [CNTW-1:0] N_CNT = CNTW'(N);

  // Stage s occupies chain[s*WIDTH +: WIDTH], so the scan chain and the
  // functional pipeline share one flat vector.
  logic [N-1:0]     chain;
  logic [N-1:0]     chain_shift;
  logic [N-1:0]     chain_load;
  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] vld_load;
  logic [CNTW-1:0]  cnt;
  logic [CNTW-1:0]  cnt_nxt;
  logic             done;

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
    return (c >= N_CNT) ? c : c + CNTW'(1);
  endfunction

  always_comb begin
    chain_shift                = chain << 1;
    chain_shift[0]             = TD;
    chain_load                 = chain << WIDTH;
    chain_load[WIDTH-1:0]      = D;
    vld_load                   = vld << 1;
    vld_load[0]                = VI;
    cnt_nxt                    = SEL ? sat_inc(cnt) : '0;
  end

  always_ff @(posedge CK or negedge RB) begin
    if (!RB) begin
      chain <= '0;
      vld   <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      done <= (cnt_nxt == N_CNT);
      // Scan outranks clear so a scan-in pattern cannot be wiped by functional control.
      if (SEL) begin
        chain <= chain_shift;
      end else if (!CLRB) begin
        chain <= '0;
        vld   <= '0;
      end else if (LD) begin
        chain <= chain_load;
        vld   <= vld_load;
      end
    end
  end

  assign Q     = chain[N-1 -: WIDTH];
  assign QB    = ~chain[N-1 -: WIDTH];
  assign VO    = vld[DEPTH-1];
  assign SO    = chain[N-1];
  assign SCNT  = cnt;
  assign SDONE = done;

endmodule

// File: tb/tb_scan_ldclr_pipe.sv
// Directed bench for scan_ldclr_pipe at WIDTH=8, DEPTH=4.
module tb_scan_ldclr_pipe;

  logic       CK = 1'b0;
  logic       RB;
  logic [7:0] D;
  logic       VI, LD, CLRB, SEL, TD;
  logic [7:0] Q, QB;
  logic       VO, SO, SDONE;
  logic [5:0] SCNT;

  int tests = 0;
  int fails = 0;
  logic [31:0] model;

  scan_ldclr_pipe #(.WIDTH(8), .DEPTH(4)) dut (
    .CK(CK), .RB(RB), .D(D), .VI(VI), .LD(LD), .CLRB(CLRB), .SEL(SEL), .TD(TD),
    .Q(Q), .QB(QB), .VO(VO), .SO(SO), .SCNT(SCNT), .SDONE(SDONE)
  );

  always #5 CK = ~CK;

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  task automatic load(input logic [7:0] d, input logic vi);
    D = d; VI = vi; LD = 1'b1; CLRB = 1'b1; SEL = 1'b0;
    step();
  endtask

  task automatic test_reset();
    RB = 1'b0;
    D = 8'($urandom); VI = 1'($urandom); LD = 1'($urandom);
    CLRB = 1'($urandom); SEL = 1'($urandom); TD = 1'($urandom);
    step(); step();
    tests++; if (Q !== 8'h00)     begin fails++; $display("FAIL reset_q got %h want 00", Q); end
    tests++; if (QB !== 8'hFF)    begin fails++; $display("FAIL reset_qb got %h want ff", QB); end
    tests++; if (VO !== 1'b0)     begin fails++; $display("FAIL reset_vo got %b want 0", VO); end
    tests++; if (SO !== 1'b0)     begin fails++; $display("FAIL reset_so got %b want 0", SO); end
    tests++; if (SCNT !== 6'd0)   begin fails++; $display("FAIL reset_scnt got %0d want 0", SCNT); end
    tests++; if (SDONE !== 1'b0)  begin fails++; $display("FAIL reset_sdone got %b want 0", SDONE); end
    RB = 1'b1; LD = 1'b0; SEL = 1'b0; CLRB = 1'b1; D = 8'h5A; VI = 1'b1;
    step(); step();
    tests++; if (Q !== 8'h00 || VO !== 1'b0 || SCNT !== 6'd0)
      begin fails++; $display("FAIL reset_hold got q=%h vo=%b scnt=%0d want 00/0/0", Q, VO, SCNT); end
  endtask

  task automatic test_fill();
    load(8'h11, 1'b1);
    load(8'h22, 1'b1);
    LD = 1'b0; D = 8'hEE; step(); step();
    tests++; if (Q !== 8'h00 || VO !== 1'b0)
      begin fails++; $display("FAIL fill_gap got q=%h vo=%b want 00/0", Q, VO); end
    load(8'h33, 1'b1);
    tests++; if (Q !== 8'h00) begin fails++; $display("FAIL fill_3rd got %h want 00", Q); end
    load(8'h44, 1'b1);
    tests++; if (Q !== 8'h11 || VO !== 1'b1)
      begin fails++; $display("FAIL fill_4th got q=%h vo=%b want 11/1", Q, VO); end
    tests++; if (QB !== 8'hEE) begin fails++; $display("FAIL fill_qb got %h want ee", QB); end
    load(8'h55, 1'b1);
    tests++; if (Q !== 8'h22) begin fails++; $display("FAIL fill_next got %h want 22", Q); end
  endtask

  task automatic test_clear_priority();
    D = 8'hAA; VI = 1'b1; LD = 1'b1; CLRB = 1'b0; SEL = 1'b0;
    step();
    tests++; if (Q !== 8'h00 || VO !== 1'b0)
      begin fails++; $display("FAIL clr_pri got q=%h vo=%b want 00/0", Q, VO); end
    load(8'hAA, 1'b1);
    load(8'h00, 1'b0);
    load(8'h00, 1'b0);
    tests++; if (Q !== 8'h00 || VO !== 1'b0)
      begin fails++; $display("FAIL clr_r0only got q=%h vo=%b want 00/0", Q, VO); end
    load(8'h00, 1'b0);
    tests++; if (Q !== 8'hAA || VO !== 1'b1)
      begin fails++; $display("FAIL clr_aa_out got q=%h vo=%b want aa/1", Q, VO); end
  endtask

  task automatic test_scan_roundtrip();
    logic [31:0] pat;
    pat = 32'hDEADBEEF;
    load(8'h11, 1'b1); load(8'h22, 1'b1); load(8'h33, 1'b1); load(8'h44, 1'b1);
    tests++; if (Q !== 8'h11 || SO !== 1'b0)
      begin fails++; $display("FAIL scan_pre got q=%h so=%b want 11/0", Q, SO); end
    model = 32'h11223344;
    SEL = 1'b1; LD = 1'b0;
    for (int i = 0; i < 32; i++) begin
      TD = pat[i];
      step();
      model = {model[30:0], pat[i]};
      tests++; if (SO !== model[31])
        begin fails++; $display("FAIL scan_so[%0d] got %b want %b", i, SO, model[31]); end
      tests++; if (SCNT !== 6'(i+1))
        begin fails++; $display("FAIL scan_cnt[%0d] got %0d want %0d", i, SCNT, i+1); end
      tests++; if (SDONE !== (i == 31))
        begin fails++; $display("FAIL scan_done[%0d] got %b want %b", i, SDONE, (i == 31)); end
    end
    tests++; if (Q !== 8'hF7) begin fails++; $display("FAIL scan_q got %h want f7", Q); end
    tests++; if (VO !== 1'b1) begin fails++; $display("FAIL scan_vo got %b want 1", VO); end
  endtask

  task automatic test_saturation_exit();
    SEL = 1'b1; CLRB = 1'b0; LD = 1'b1; TD = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      model = {model[30:0], 1'b0};
      tests++; if (SCNT !== 6'd32 || SDONE !== 1'b1)
        begin fails++; $display("FAIL sat[%0d] got scnt=%0d done=%b want 32/1", i, SCNT, SDONE); end
      tests++; if (SO !== model[31] || VO !== 1'b1)
        begin fails++; $display("FAIL sat_shift[%0d] got so=%b vo=%b want %b/1", i, SO, VO, model[31]); end
    end
    tests++; if (Q !== model[31:24]) begin fails++; $display("FAIL sat_q got %h want %h", Q, model[31:24]); end
    SEL = 1'b0; CLRB = 1'b1; LD = 1'b0;
    step();
    tests++; if (SCNT !== 6'd0 || SDONE !== 1'b0)
      begin fails++; $display("FAIL exit got scnt=%0d done=%b want 0/0", SCNT, SDONE); end
    tests++; if (Q !== model[31:24]) begin fails++; $display("FAIL exit_hold got %h want %h", Q, model[31:24]); end
  endtask

  task automatic test_async_reset_mid_scan();
    SEL = 1'b1; TD = 1'b1; CLRB = 1'b1; LD = 1'b0;
    for (int i = 0; i < 10; i++) step();
    tests++; if (SCNT !== 6'd10) begin fails++; $display("FAIL mid_cnt got %0d want 10", SCNT); end
    #2 RB = 1'b0;
    #1;
    tests++; if (Q !== 8'h00 || QB !== 8'hFF || VO !== 1'b0)
      begin fails++; $display("FAIL async_data got q=%h qb=%h vo=%b want 00/ff/0", Q, QB, VO); end
    tests++; if (SO !== 1'b0 || SCNT !== 6'd0 || SDONE !== 1'b0)
      begin fails++; $display("FAIL async_scan got so=%b scnt=%0d done=%b want 0/0/0", SO, SCNT, SDONE); end
    #1 RB = 1'b1;
    step();
    tests++; if (SCNT !== 6'd1 || SO !== 1'b0)
      begin fails++; $display("FAIL resume got scnt=%0d so=%b want 1/0", SCNT, SO); end
  endtask

  initial begin
    RB = 1'b0; D = '0; VI = 1'b0; LD = 1'b0; CLRB = 1'b1; SEL = 1'b0; TD = 1'b0;
    test_reset();
    test_fill();
    test_clear_priority();
    test_scan_roundtrip();
    test_saturation_exit();
    test_async_reset_mid_scan();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
